// File: rtl/iterative_seq_gen.sv
// Iterative generator for x(k) = x(k-1) + x(k-2) with Fibonacci (0,1) or Lucas (2,1) seeds.
// Latency: result valid in the cycle after edge E+max(n-1,0), where E is the start-sampling edge.
// Backpressure: none downstream; ready is high only in IDLE, and a start while busy is dropped.
//
// Ports:
//   clk_i    clock, all state on posedge
//   rst_i    synchronous active-high reset (abandons any run in progress)
//   start_i  request, sampled only while ready_o=1
//   n_i      term index, latched with start
//   mode_i   0 = Fibonacci seeds, 1 = Lucas seeds, latched with start
//   ready_o  high in IDLE only
//   valid_o  one-cycle pulse when out_o/ovf_o hold a new result
//   out_o    result register, saturates to all-ones on overflow
//   ovf_o    result saturated, updated together with out_o
module iterative_seq_gen #(
    parameter int W  = 16,
    parameter int NW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [NW-1:0] n_i,
    input  logic          mode_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [W-1:0]  out_o,
    output logic          ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [NW-1:0] count_q, count_d;
    logic [NW-1:0] nl_q, nl_d;
    logic          sat_q, sat_d;
    logic [W-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d;

    // One extra bit on the sum exposes the carry used for saturation.
    logic [W:0]    sum;
    logic [W-1:0]  seed0;
    logic [NW-1:0] count_inc;

    assign sum       = {1'b0, cur_q} + {1'b0, prev_q};
    assign seed0     = mode_i ? W'(2) : '0;
    assign count_inc = count_q + NW'(1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        count_d = count_q;
        nl_d    = nl_q;
        sat_d   = sat_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // The mode only selects seeds, so it is fully captured in prev/cur here.
                    nl_d    = n_i;
                    prev_d  = seed0;
                    cur_d   = W'(1);
                    count_d = NW'(1);
                    sat_d   = 1'b0;
                    if (n_i <= NW'(1)) begin
                        // n=0 returns seed0, n=1 returns seed1 (1 in both modes).
                        state_d = S_DONE;
                        out_d   = (n_i == '0) ? seed0 : W'(1);
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                prev_d  = cur_q;
                count_d = count_inc;
                // Once saturated, stay saturated even if the modulo sum would look small.
                if (sum[W] || sat_q) begin
                    cur_d = '1;
                    sat_d = 1'b1;
                end else begin
                    cur_d = sum[W-1:0];
                end
                if (count_inc == nl_q) begin
                    state_d = S_DONE;
                    out_d   = cur_d;
                    ovf_d   = sat_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            prev_q  <= '0;
            cur_q   <= '0;
            count_q <= '0;
            nl_q    <= '0;
            sat_q   <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            nl_q    <= nl_d;
            sat_q   <= sat_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign out_o   = out_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_iterative_seq_gen.sv
// Scoreboard bench for iterative_seq_gen: directed requests push expected results, a monitor pops on valid.
// Latency is checked against the cycle predicted at issue time.
// Also checks ready returns and valid drops one cycle after each result.
module tb_iterative_seq_gen;
    localparam int W  = 16;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n;
    logic          mode;
    logic          ready;
    logic          valid;
    logic [W-1:0]  out;
    logic          ovf;

    iterative_seq_gen #(.W(W), .NW(NW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .n_i     (n),
        .mode_i  (mode),
        .ready_o (ready),
        .valid_o (valid),
        .out_o   (out),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] out;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per valid pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                chk("ready_after_valid", 32'(ready), 32'd1);
                chk("valid_one_cycle", 32'(valid), 32'd0);
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_out", 32'(out), 32'(e.out));
                    chk("result_ovf", 32'(ovf), 32'(e.ovf));
                    chk("result_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_valid = valid;
        end
    end

    // Wait for ready, pulse start for one sampling edge, optionally push the expected result.
    task automatic issue(input bit m, input int nn, input int eo, input bit ev, input bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            return;
        end
        start = 1'b1;
        n     = NW'(nn);
        mode  = m;
        if (push) begin
            e.out = W'(eo);
            e.ovf = ev;
            e.cyc = cyc + 1 + ((nn > 1) ? nn - 1 : 0);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        mode  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        // Basic Fibonacci / Lucas values and n=0/1/2 corners.
        issue(1'b0, 10, 55, 1'b0, 1'b1);
        issue(1'b1, 5, 11, 1'b0, 1'b1);
        issue(1'b1, 0, 2, 1'b0, 1'b1);
        issue(1'b0, 1, 1, 1'b0, 1'b1);
        issue(1'b0, 0, 0, 1'b0, 1'b1);
        issue(1'b1, 1, 1, 1'b0, 1'b1);
        issue(1'b0, 2, 1, 1'b0, 1'b1);
        issue(1'b1, 2, 3, 1'b0, 1'b1);
        wait_drain();

        // Overflow boundary at W=16.
        issue(1'b0, 24, 46368, 1'b0, 1'b1);
        issue(1'b0, 25, 65535, 1'b1, 1'b1);
        issue(1'b0, 30, 65535, 1'b1, 1'b1);
        issue(1'b1, 23, 64079, 1'b0, 1'b1);
        issue(1'b1, 24, 65535, 1'b1, 1'b1);
        issue(1'b0, 63, 65535, 1'b1, 1'b1);
        wait_drain();

        // Start pulsed mid-run must be dropped; the following request runs normally.
        issue(1'b0, 10, 55, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        n     = NW'(3);
        @(negedge clk);
        start = 1'b0;
        issue(1'b0, 3, 2, 1'b0, 1'b1);
        wait_drain();

        // Reset four cycles into an n=20 run: no result, outputs cleared.
        issue(1'b0, 20, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        repeat (25) @(negedge clk);
        issue(1'b0, 7, 13, 1'b0, 1'b1);
        wait_drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
